mc_main_control: RTL

- Multicycle MIPS main control FSM. It produces the aluop1/aluop0 pair consumed by alucont, plus every datapath enable and select for the multicycle datapath.
- Decodes the 6-bit opcode from the instruction register and steps through fetch, decode, execute, memory and writeback states.
- Supports R-type, lw, sw, beq, j and ori.

---
 rtl/mc_ctrl_pkg.sv | 59 +++++
 rtl/mc_ctrl_outdec.sv | 79 +++++++
 rtl/mc_main_control.sv | 86 ++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared constants and types for the multicycle MIPS main control FSM.
package mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ORI   = 2'b11;

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StRwb    = 4'd7,
        StBeq    = 4'd8,
        StJump   = 4'd9,
        StOriEx  = 4'd10,
        StOriWb  = 4'd11
    } state_e;

    typedef struct packed {
        logic       pcwrite;
        logic       pcwritecond;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       irwrite;
        logic       regdst;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       zext;
        logic [1:0] pcsource;
        logic [1:0] aluop;
        logic       instr_done;
    } ctrl_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        logic legal;
        legal = 1'b0;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ORI: legal = 1'b1;
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Moore output decode: maps the current state to every datapath control.
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
(
    input  state_e state_i,
    output ctrl_t  ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            StFetch: begin
                ctrl_o.memread = 1'b1;
                ctrl_o.irwrite = 1'b1;
                ctrl_o.alusrcb = 2'b01;
                ctrl_o.pcwrite = 1'b1;
                ctrl_o.aluop   = ALUOP_ADD;
            end
            StDecode: begin
                ctrl_o.alusrcb = 2'b11;
                ctrl_o.aluop   = ALUOP_ADD;
            end
            StMemAdr: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.alusrcb = 2'b10;
                ctrl_o.aluop   = ALUOP_ADD;
            end
            StMemRd: begin
                ctrl_o.memread = 1'b1;
                ctrl_o.iord    = 1'b1;
            end
            StMemWb: begin
                ctrl_o.regwrite   = 1'b1;
                ctrl_o.memtoreg   = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            StMemWr: begin
                ctrl_o.memwrite   = 1'b1;
                ctrl_o.iord       = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            StExec: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.alusrcb = 2'b00;
                ctrl_o.aluop   = ALUOP_RTYPE;
            end
            StRwb: begin
                ctrl_o.regdst     = 1'b1;
                ctrl_o.regwrite   = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            StBeq: begin
                ctrl_o.alusrca     = 1'b1;
                ctrl_o.alusrcb     = 2'b00;
                ctrl_o.aluop       = ALUOP_SUB;
                ctrl_o.pcwritecond = 1'b1;
                ctrl_o.pcsource    = 2'b01;
                ctrl_o.instr_done  = 1'b1;
            end
            StJump: begin
                ctrl_o.pcwrite    = 1'b1;
                ctrl_o.pcsource   = 2'b10;
                ctrl_o.instr_done = 1'b1;
            end
            StOriEx: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.alusrcb = 2'b10;
                ctrl_o.zext    = 1'b1;
                ctrl_o.aluop   = ALUOP_ORI;
            end
            StOriWb: begin
                ctrl_o.regwrite   = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/mc_main_control.sv
// Multicycle MIPS main control: state register, next-state decode and output fan-out.
module mc_main_control
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    output logic       pcwrite,
    output logic       pcwritecond,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       memtoreg,
    output logic       irwrite,
    output logic       regdst,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       zext,
    output logic [1:0] pcsource,
    output logic       aluop1,
    output logic       aluop0,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);

    state_e state_q, state_d;
    ctrl_t  ctrl;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = StFetch;
        case (state_q)
            StFetch: state_d = StDecode;
            StDecode: begin
                case (op)
                    OP_RTYPE:     state_d = StExec;
                    OP_LW, OP_SW: state_d = StMemAdr;
                    OP_BEQ:       state_d = StBeq;
                    OP_J:         state_d = StJump;
                    OP_ORI:       state_d = StOriEx;
                    default:      state_d = StFetch;
                endcase
            end
            // Only lw and sw reach here, and the IR holds op steady.
            StMemAdr: state_d = (op == OP_SW) ? StMemWr : StMemRd;
            StMemRd:  state_d = StMemWb;
            StExec:   state_d = StRwb;
            StOriEx:  state_d = StOriWb;
            default:  state_d = StFetch;
        endcase
    end

    mc_ctrl_outdec u_outdec (
        .state_i (state_q),
        .ctrl_o  (ctrl)
    );

    assign pcwrite     = ctrl.pcwrite;
    assign pcwritecond = ctrl.pcwritecond;
    assign iord        = ctrl.iord;
    assign memread     = ctrl.memread;
    assign memwrite    = ctrl.memwrite;
    assign memtoreg    = ctrl.memtoreg;
    assign irwrite     = ctrl.irwrite;
    assign regdst      = ctrl.regdst;
    assign regwrite    = ctrl.regwrite;
    assign alusrca     = ctrl.alusrca;
    assign alusrcb     = ctrl.alusrcb;
    assign zext        = ctrl.zext;
    assign pcsource    = ctrl.pcsource;
    assign aluop1      = ctrl.aluop[1];
    assign aluop0      = ctrl.aluop[0];
    assign instr_done  = ctrl.instr_done;
    assign illegal     = (state_q == StDecode) && !is_legal_op(op);
    assign state       = state_q;

endmodule
